// File: rtl/rr_burst_arbiter_if.sv
// Requester-side FIFO heads/pops and downstream AW/W channel of the burst arbiter.
// master = arbiter side, slave = upstream FIFOs plus downstream sink.
interface rr_burst_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned AW_W  = 49,
  parameter int unsigned W_W   = 37
);
  localparam int unsigned IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0]      REQ_AW_VALID_i;
  logic [N_REQ*AW_W-1:0] REQ_AW_DATA_i;
  logic [N_REQ-1:0]      REQ_AW_POP_o;
  logic [N_REQ-1:0]      REQ_W_VALID_i;
  logic [N_REQ*W_W-1:0]  REQ_W_DATA_i;
  logic [N_REQ-1:0]      REQ_W_POP_o;
  logic                  M_AW_VALID_o;
  logic [IDX_W+AW_W-1:0] M_AW_DATA_o;
  logic                  M_AW_READY_i;
  logic                  M_W_VALID_o;
  logic [W_W-1:0]        M_W_DATA_o;
  logic                  M_W_READY_i;
  logic [IDX_W-1:0]      GRANT_IDX_o;
  logic                  BUSY_o;
  logic                  LAST_ERR_o;

  modport master (
    input  REQ_AW_VALID_i, REQ_AW_DATA_i, REQ_W_VALID_i, REQ_W_DATA_i,
           M_AW_READY_i, M_W_READY_i,
    output REQ_AW_POP_o, REQ_W_POP_o, M_AW_VALID_o, M_AW_DATA_o,
           M_W_VALID_o, M_W_DATA_o, GRANT_IDX_o, BUSY_o, LAST_ERR_o
  );

  modport slave (
    output REQ_AW_VALID_i, REQ_AW_DATA_i, REQ_W_VALID_i, REQ_W_DATA_i,
           M_AW_READY_i, M_W_READY_i,
    input  REQ_AW_POP_o, REQ_W_POP_o, M_AW_VALID_o, M_AW_DATA_o,
           M_W_VALID_o, M_W_DATA_o, GRANT_IDX_o, BUSY_o, LAST_ERR_o
  );
endinterface

// File: rtl/rr_burst_arbiter.sv
// Round-robin AXI write arbiter: grants one requester's AW, then locks the W path
// to it for LEN+1 beats, regenerating LAST from its own beat counter.
module rr_burst_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned AW_W  = 49,
  parameter int unsigned W_W   = 37
) (
  input  logic           AXI_CLK_i,
  input  logic           AXI_RST_i,
  rr_burst_arbiter_if.master bus
);
  localparam int unsigned IDX_W   = $clog2(N_REQ);
  localparam int unsigned LEN_LSB = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [7:0]       beat_cnt_q, beat_cnt_d;
  logic             last_err_q, last_err_d;

  logic [AW_W-1:0]  aw_head [N_REQ];
  logic [W_W-1:0]   w_head  [N_REQ];

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand;

  logic                  aw_valid, w_valid, w_last;
  logic [IDX_W+AW_W-1:0] aw_data;
  logic [W_W-1:0]        w_data;
  logic [N_REQ-1:0]      aw_pop, w_pop;

  for (genvar g = 0; g < N_REQ; g++) begin : g_heads
    assign aw_head[g] = bus.REQ_AW_DATA_i[g*AW_W +: AW_W];
    assign w_head[g]  = bus.REQ_W_DATA_i[g*W_W +: W_W];
  end

  // Scan starts at rr_ptr and wraps, so the lowest-priority slot is the one just served.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = rr_ptr_q;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!win_found && bus.REQ_AW_VALID_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
      cand = (cand == IDX_W'(N_REQ - 1)) ? '0 : cand + IDX_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    last_err_d = 1'b0;
    aw_valid   = 1'b0;
    aw_data    = '0;
    aw_pop     = '0;
    w_valid    = 1'b0;
    w_last     = 1'b0;
    w_data     = '0;
    w_pop      = '0;

    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d  = win_idx;
          rr_ptr_d = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
          state_d  = S_ADDR;
        end
      end
      S_ADDR: begin
        aw_valid = 1'b1;
        aw_data  = {grant_q, aw_head[grant_q]};
        if (bus.M_AW_READY_i) begin
          aw_pop[grant_q] = 1'b1;
          beat_cnt_d      = aw_head[grant_q][LEN_LSB +: 8];
          state_d         = S_DATA;
        end
      end
      S_DATA: begin
        w_last  = (beat_cnt_q == 8'd0);
        w_valid = bus.REQ_W_VALID_i[grant_q];
        w_data  = {w_head[grant_q][W_W-1:1], w_last};
        if (w_valid && bus.M_W_READY_i) begin
          w_pop[grant_q] = 1'b1;
          // Upstream LAST is only audited; the counter decides where the burst ends.
          last_err_d     = (w_head[grant_q][0] != w_last);
          if (w_last) state_d = S_IDLE;
          else        beat_cnt_d = beat_cnt_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge AXI_CLK_i or negedge AXI_RST_i) begin
    if (!AXI_RST_i) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
      last_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
      last_err_q <= last_err_d;
    end
  end

  assign bus.M_AW_VALID_o = aw_valid;
  assign bus.M_AW_DATA_o  = aw_data;
  assign bus.REQ_AW_POP_o = aw_pop;
  assign bus.M_W_VALID_o  = w_valid;
  assign bus.M_W_DATA_o   = w_data;
  assign bus.REQ_W_POP_o  = w_pop;
  assign bus.GRANT_IDX_o  = grant_q;
  assign bus.BUSY_o       = (state_q != S_IDLE);
  assign bus.LAST_ERR_o   = last_err_q;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Bench for rr_burst_arbiter: queue-modelled upstream FIFOs, a round-robin
// reference model feeding expected AW/W streams, and a negedge scoreboard monitor.
module tb_rr_burst_arbiter;
  localparam int unsigned N_REQ = 4;
  localparam int unsigned AW_W  = 49;
  localparam int unsigned W_W   = 37;
  localparam int unsigned IDX_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  rr_burst_arbiter_if #(.N_REQ(N_REQ), .AW_W(AW_W), .W_W(W_W)) bus ();
  rr_burst_arbiter #(.N_REQ(N_REQ), .AW_W(AW_W), .W_W(W_W)) dut (
    .AXI_CLK_i(clk),
    .AXI_RST_i(rst_n),
    .bus(bus)
  );

  typedef struct packed {
    logic [W_W-1:0]   data;
    logic             err;
    logic [IDX_W-1:0] idx;
  } wexp_t;

  logic [AW_W-1:0]       aw_fifo [N_REQ][$];
  logic [W_W-1:0]        w_fifo  [N_REQ][$];
  logic [AW_W-1:0]       stg_aw  [N_REQ][$];
  logic [W_W-1:0]        stg_w   [N_REQ][$];
  int                    lens    [N_REQ][$];
  logic [IDX_W+AW_W-1:0] exp_aw [$];
  wexp_t                 exp_w  [$];
  int unsigned           model_ptr;

  int errors = 0;
  int checks = 0;
  logic [N_REQ-1:0] aw_pop_s = '0;
  logic [N_REQ-1:0] w_pop_s  = '0;
  logic             exp_err_next = 1'b0;
  bit               rand_ready, rand_gate, rand_flip;
  logic             fix_aw_ready, fix_w_ready;
  logic [N_REQ-1:0] w_gate;
  logic [AW_W-1:0]  last_aw;
  logic [IDX_W+AW_W-1:0] held_aw;
  int last_hs, n_aw, err_pulses;
  logic prev_v;
  int order [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [N_REQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic drive();
    bit g;
    for (int r = 0; r < N_REQ; r++) begin
      g = rand_gate ? ($urandom_range(0, 3) != 0) : w_gate[r];
      bus.REQ_AW_VALID_i[r] = (aw_fifo[r].size() != 0);
      bus.REQ_AW_DATA_i[r*AW_W +: AW_W] = (aw_fifo[r].size() != 0) ? aw_fifo[r][0] : '0;
      bus.REQ_W_VALID_i[r] = (w_fifo[r].size() != 0) && g;
      bus.REQ_W_DATA_i[r*W_W +: W_W] = (w_fifo[r].size() != 0) ? w_fifo[r][0] : '0;
    end
    bus.M_AW_READY_i = rand_ready ? ($urandom_range(0, 2) != 0) : fix_aw_ready;
    bus.M_W_READY_i  = rand_ready ? ($urandom_range(0, 2) != 0) : fix_w_ready;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int r = 0; r < N_REQ; r++) begin
      if (aw_pop_s[r] && aw_fifo[r].size() != 0) void'(aw_fifo[r].pop_front());
      if (w_pop_s[r] && w_fifo[r].size() != 0) void'(w_fifo[r].pop_front());
    end
    drive();
  endtask

  // Fills the FIFOs from lens[] and derives the expected streams by replaying
  // round-robin over whichever requesters still hold bursts.
  task automatic load(input int flip_beat);
    logic [AW_W-1:0] aw;
    logic [W_W-1:0]  w;
    logic            lst, flip, found;
    int              len;
    int unsigned     c;
    wexp_t           we;
    for (int r = 0; r < N_REQ; r++) begin
      foreach (lens[r][k]) begin
        aw = {4'($urandom()), 32'($urandom()), 8'(lens[r][k]), 3'($urandom()), 2'($urandom())};
        aw_fifo[r].push_back(aw);
        stg_aw[r].push_back(aw);
        last_aw = aw;
        for (int b = 0; b <= lens[r][k]; b++) begin
          lst  = (b == lens[r][k]);
          flip = (b == flip_beat) || (rand_flip && $urandom_range(0, 7) == 0);
          w = {32'($urandom()), 4'($urandom()), lst ^ flip};
          w_fifo[r].push_back(w);
          stg_w[r].push_back(w);
        end
      end
      lens[r].delete();
    end
    forever begin
      found = 1'b0;
      c = 0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
        if (!found && stg_aw[(model_ptr + k) % N_REQ].size() != 0) begin
          found = 1'b1;
          c = (model_ptr + k) % N_REQ;
        end
      end
      if (!found) break;
      model_ptr = (c + 1) % N_REQ;
      aw = stg_aw[c].pop_front();
      exp_aw.push_back({IDX_W'(c), aw});
      len = int'(aw[12:5]);
      for (int b = 0; b <= len; b++) begin
        w = stg_w[c].pop_front();
        lst = (b == len);
        we.data = {w[W_W-1:1], lst};
        we.err  = (w[0] != lst);
        we.idx  = IDX_W'(c);
        exp_w.push_back(we);
      end
    end
    drive();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_aw_valid"}, bus.M_AW_VALID_o, 0);
    chk({tag, "_aw_data"},  bus.M_AW_DATA_o, 0);
    chk({tag, "_w_valid"},  bus.M_W_VALID_o, 0);
    chk({tag, "_w_data"},   bus.M_W_DATA_o, 0);
    chk({tag, "_aw_pop"},   bus.REQ_AW_POP_o, 0);
    chk({tag, "_w_pop"},    bus.REQ_W_POP_o, 0);
    chk({tag, "_grant"},    bus.GRANT_IDX_o, 0);
    chk({tag, "_busy"},     bus.BUSY_o, 0);
    chk({tag, "_last_err"}, bus.LAST_ERR_o, 0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    exp_aw.delete();
    exp_w.delete();
    for (int r = 0; r < N_REQ; r++) begin
      aw_fifo[r].delete();
      w_fifo[r].delete();
      stg_aw[r].delete();
      stg_w[r].delete();
      lens[r].delete();
    end
    model_ptr = 0;
    exp_err_next = 1'b0;
    aw_pop_s = '0;
    w_pop_s = '0;
    drive();
    #1;
    chk_zero(tag);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_aw.size() != 0 || exp_w.size() != 0 || bus.BUSY_o) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d aw / %0d w outstanding after %0d cycles, required 0",
               exp_aw.size(), exp_w.size(), n);
      exp_aw.delete();
      exp_w.delete();
    end
    step();
    n = 0;
    for (int r = 0; r < N_REQ; r++) n += aw_fifo[r].size() + w_fifo[r].size();
    chk("fifos_drained", n, 0);
  endtask

  // Scoreboard monitor
  initial begin : monitor
    logic [IDX_W+AW_W-1:0] ea;
    wexp_t ew;
    forever begin
      @(negedge clk);
      aw_pop_s = bus.REQ_AW_POP_o;
      w_pop_s  = bus.REQ_W_POP_o;
      if (rst_n) begin
        chk("last_err", bus.LAST_ERR_o, exp_err_next);
        exp_err_next = 1'b0;
        if (bus.M_AW_VALID_o && bus.M_AW_READY_i) begin
          if (exp_aw.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL aw_unexpected: got %0h with no AW expected at %0t", bus.M_AW_DATA_o, $time);
          end else begin
            ea = exp_aw.pop_front();
            chk("aw_data", bus.M_AW_DATA_o, ea);
            chk("aw_pop", bus.REQ_AW_POP_o, onehot(ea[AW_W +: IDX_W]));
            chk("grant_idx", bus.GRANT_IDX_o, ea[AW_W +: IDX_W]);
          end
        end else begin
          chk("aw_pop_idle", bus.REQ_AW_POP_o, 0);
        end
        if (bus.M_W_VALID_o && bus.M_W_READY_i) begin
          if (exp_w.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL w_unexpected: got %0h with no W beat expected at %0t", bus.M_W_DATA_o, $time);
          end else begin
            ew = exp_w.pop_front();
            chk("w_data", bus.M_W_DATA_o, ew.data);
            chk("w_pop", bus.REQ_W_POP_o, onehot(ew.idx));
            exp_err_next = ew.err;
          end
        end else begin
          chk("w_pop_idle", bus.REQ_W_POP_o, 0);
        end
      end else begin
        exp_err_next = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin : main
    rand_ready = 0; rand_gate = 0; rand_flip = 0;
    fix_aw_ready = 1'b1; fix_w_ready = 1'b1; w_gate = '1;
    model_ptr = 0;
    order = '{0, 1, 2, 3, 0};
    drive();
    #2;
    do_reset("reset");
    step();

    // Single requester 2, LEN=3, full readiness
    lens[2].push_back(3);
    load(-1);
    @(negedge clk);
    chk("t1_c0_aw_valid", bus.M_AW_VALID_o, 0);
    step(); @(negedge clk);
    chk("t1_aw_valid", bus.M_AW_VALID_o, 1);
    chk("t1_aw_idx", bus.M_AW_DATA_o[AW_W +: IDX_W], 2);
    for (int c = 2; c <= 5; c++) begin
      step(); @(negedge clk);
      chk("t1_w_valid", bus.M_W_VALID_o, 1);
      chk("t1_w_last", bus.M_W_DATA_o[0], (c == 5));
      chk("t1_w_pop", bus.REQ_W_POP_o, 4'b0100);
    end
    step(); @(negedge clk);
    chk("t1_after_w_valid", bus.M_W_VALID_o, 0);
    chk("t1_after_busy", bus.BUSY_o, 0);
    drain(100);

    // All requesters, LEN=0: order 0,1,2,3,0 with one idle bubble
    do_reset("reset2");
    step();
    lens[0].push_back(0); lens[0].push_back(0);
    lens[1].push_back(0); lens[2].push_back(0); lens[3].push_back(0);
    load(-1);
    last_hs = -1; n_aw = 0; prev_v = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (cyc != 0) step();
      @(negedge clk);
      if (bus.M_AW_VALID_o && !prev_v && last_hs >= 0) chk("t2_bubble", cyc - last_hs, 2);
      if (bus.M_AW_VALID_o && bus.M_AW_READY_i && n_aw < 5) begin
        chk("t2_order", bus.M_AW_DATA_o[AW_W +: IDX_W], order[n_aw]);
        n_aw++;
      end
      if (bus.M_W_VALID_o && bus.M_W_READY_i && bus.M_W_DATA_o[0]) last_hs = cyc;
      prev_v = bus.M_AW_VALID_o;
    end
    chk("t2_bursts", n_aw, 5);
    drain(50);

    // AW backpressure then a 2-cycle upstream W gap
    fix_aw_ready = 1'b0;
    lens[1].push_back(3);
    load(-1);
    held_aw = {IDX_W'(1), last_aw};
    @(negedge clk);
    for (int k = 1; k <= 3; k++) begin
      step(); @(negedge clk);
      chk("t3_aw_hold_valid", bus.M_AW_VALID_o, 1);
      chk("t3_aw_hold_data", bus.M_AW_DATA_o, held_aw);
      chk("t3_no_pop", bus.REQ_AW_POP_o, 0);
    end
    fix_aw_ready = 1'b1;
    step(); @(negedge clk);
    step(); @(negedge clk);
    w_gate = 4'b1101;
    for (int k = 0; k < 2; k++) begin
      step(); @(negedge clk);
      chk("t4_gap_w_valid", bus.M_W_VALID_o, 0);
      chk("t4_gap_busy", bus.BUSY_o, 1);
    end
    w_gate = '1;
    drain(50);

    // Upstream LAST on beat 1 of a LEN=2 burst
    lens[0].push_back(2);
    load(1);
    err_pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.LAST_ERR_o) err_pulses++;
      step();
    end
    chk("t5_err_pulses", err_pulses, 1);
    drain(20);

    // Reset during beat 1 of a LEN=7 burst, then rr pointer must restart at 0
    lens[1].push_back(7);
    load(-1);
    repeat (3) step();
    @(negedge clk);
    #2;
    do_reset("mid_reset");
    step();
    lens[1].push_back(0); lens[3].push_back(0);
    load(-1);
    drain(50);

    // Randomized traffic, backpressure, gaps and LAST corruption
    rand_ready = 1; rand_gate = 1; rand_flip = 1;
    for (int round = 0; round < 20; round++) begin
      for (int r = 0; r < N_REQ; r++) begin
        for (int k = 0; k < int'($urandom_range(0, 3)); k++)
          lens[r].push_back(($urandom_range(0, 19) == 0) ? 255 : int'($urandom_range(0, 7)));
      end
      if (round == 5) lens[2].push_back(255);
      load(-1);
      drain(4000);
    end
    rand_ready = 0; rand_gate = 0;
    drive();
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
